// File: rtl/uart_report_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_report_arbiter
// Description : Round-robin arbiter that frames 16-bit report words into
//               5-byte packets (sync, id, hi, lo, checksum) for a byte UART TX.
// Revision    : 1.0
// ============================================================================
module uart_report_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [16*NUM_REQ-1:0]  req_data,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic                   busy,
  output logic [3:0]             grant_id
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_SYNC = 3'd1;
  localparam logic [2:0] S_ID   = 3'd2;
  localparam logic [2:0] S_HI   = 3'd3;
  localparam logic [2:0] S_LO   = 3'd4;
  localparam logic [2:0] S_CHK  = 3'd5;

  logic [2:0]  state_q, state_d;
  logic [3:0]  ptr_q, ptr_d;
  logic [3:0]  id_q, id_d;
  logic [3:0]  grant_id_q, grant_id_d;
  logic [15:0] word_q, word_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_valid_q, tx_valid_d;
  logic        busy_q, busy_d;

  logic [15:0] valid_ext;
  logic        win_found;
  logic [3:0]  win_idx;
  logic [15:0] win_word;
  logic        grant;
  logic        xfer;
  logic [7:0]  chk;
  logic [4:0]  ptr_inc;

  // Zero-extend so a 4-bit index is always in range regardless of NUM_REQ.
  assign valid_ext = 16'(req_valid);

  always_comb begin
    logic [4:0] cand;
    win_found = 1'b0;
    win_idx   = 4'd0;
    cand      = 5'd0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr_q} + 5'(k);
      if (cand >= 5'(NUM_REQ)) cand = cand - 5'(NUM_REQ);
      if (!win_found && valid_ext[cand[3:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[3:0];
      end
    end
  end

  always_comb begin
    win_word = 16'h0000;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == 4'(i)) win_word = req_data[16*i +: 16];
    end
  end

  assign grant   = (state_q == S_IDLE) && win_found && !rst;
  assign xfer    = tx_valid_q && tx_ready;
  assign chk     = SYNC_BYTE ^ {4'h0, id_q} ^ word_q[15:8] ^ word_q[7:0];
  assign ptr_inc = {1'b0, id_q} + 5'd1;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = grant && (win_idx == 4'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ptr_q      <= 4'd0;
      id_q       <= 4'd0;
      word_q     <= 16'h0000;
      grant_id_q <= 4'd0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      id_q       <= id_d;
      word_q     <= word_d;
      grant_id_q <= grant_id_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (grant) state_d = S_SYNC;
      S_SYNC:  if (xfer)  state_d = S_ID;
      S_ID:    if (xfer)  state_d = S_HI;
      S_HI:    if (xfer)  state_d = S_LO;
      S_LO:    if (xfer)  state_d = S_CHK;
      S_CHK:   if (xfer)  state_d = S_IDLE;
      default:            state_d = S_IDLE;
    endcase
  end

  // Each accepted byte loads the next one, so tx_data is held during stalls.
  always_comb begin
    ptr_d      = ptr_q;
    id_d       = id_q;
    word_d     = word_q;
    grant_id_d = grant_id_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    busy_d     = (state_d != S_IDLE);
    if (grant) begin
      id_d       = win_idx;
      word_d     = win_word;
      grant_id_d = win_idx;
      tx_data_d  = SYNC_BYTE;
      tx_valid_d = 1'b1;
    end else if (xfer) begin
      case (state_q)
        S_SYNC: tx_data_d = {4'h0, id_q};
        S_ID:   tx_data_d = word_q[15:8];
        S_HI:   tx_data_d = word_q[7:0];
        S_LO:   tx_data_d = chk;
        S_CHK: begin
          tx_valid_d = 1'b0;
          ptr_d      = (ptr_inc >= 5'(NUM_REQ)) ? 4'd0 : ptr_inc[3:0];
        end
        default: tx_valid_d = 1'b0;
      endcase
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign busy     = busy_q;
  assign grant_id = grant_id_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_report_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for uart_report_arbiter: directed steps, expected grants and bytes
// queued at drive time and matched by negedge monitors.
module tb_uart_report_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = 4'h0;
  logic [63:0] req_data = 64'h0;
  logic [3:0]  req_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        busy;
  logic [3:0]  grant_id;

  int n_total  = 0;
  int n_pass   = 0;
  int n_grants = 0;
  int base;
  int mon_g;
  logic [7:0] mon_b;

  logic [7:0] exp_bytes[$];
  int         exp_grants[$];

  always #5 clk = ~clk;

  uart_report_arbiter #(
    .NUM_REQ   (4),
    .SYNC_BYTE (8'hA5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin n_pass++; end
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic push_packet(input int id, input logic [15:0] word);
    logic [7:0] idb;
    idb = 8'(id);
    exp_grants.push_back(id);
    exp_bytes.push_back(8'hA5);
    exp_bytes.push_back(idb);
    exp_bytes.push_back(word[15:8]);
    exp_bytes.push_back(word[7:0]);
    exp_bytes.push_back(8'hA5 ^ idb ^ word[15:8] ^ word[7:0]);
  endtask

  task automatic wait_grants(input int target);
    int cyc;
    cyc = 0;
    while (n_grants < target && cyc < 100) begin
      @(posedge clk);
      cyc++;
    end
    check("grant_timeout", 32'(n_grants >= target), 32'd1);
  endtask

  task automatic wait_idle();
    int cyc;
    cyc = 0;
    @(negedge clk);
    while ((busy !== 1'b0 || exp_bytes.size() != 0) && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("idle_timeout", 32'(cyc < 200), 32'd1);
  endtask

  // Grant monitor: every req_ready pulse must match the next predicted winner.
  always @(negedge clk) begin
    if (req_ready !== 4'b0000) begin
      n_grants++;
      if (exp_grants.size() == 0) begin
        check("unexpected_grant", 32'(req_ready), 32'd0);
      end else begin
        mon_g = exp_grants.pop_front();
        check("req_ready", 32'(req_ready), 32'(4'b0001 << mon_g));
      end
    end
  end

  // Byte monitor: every accepted byte must match the scoreboard head.
  always @(negedge clk) begin
    if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
      if (exp_bytes.size() == 0) begin
        check("unexpected_byte", 32'(tx_data), 32'h100);
      end else begin
        mon_b = exp_bytes.pop_front();
        check("tx_byte", 32'(tx_data), 32'(mon_b));
      end
    end
  end

  initial begin
    // Reset held with every requester valid
    rst       = 1'b1;
    req_valid = 4'hF;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_tx_valid", 32'(tx_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_grant_id", 32'(grant_id), 32'd0);
    end
    check("rst_tx_data", 32'(tx_data), 32'd0);
    @(posedge clk); #1;
    rst       = 1'b0;
    req_valid = 4'h0;

    // Single packet from requester 2
    @(posedge clk); #1;
    req_data[47:32] = 16'h1234;
    req_valid       = 4'b0100;
    push_packet(2, 16'h1234);
    base = n_grants;
    wait_grants(base + 1);
    #1 req_valid = 4'h0;
    @(negedge clk);
    check("first_byte_valid", 32'(tx_valid), 32'd1);
    check("first_byte_data", 32'(tx_data), 32'hA5);
    check("ready_one_cycle", 32'(req_ready), 32'd0);
    repeat (3) @(negedge clk);
    @(negedge clk);
    check("last_byte_busy", 32'(busy), 32'd1);
    check("last_byte_data", 32'(tx_data), 32'h81);
    @(negedge clk);
    check("after_pkt_busy", 32'(busy), 32'd0);
    check("after_pkt_valid", 32'(tx_valid), 32'd0);
    check("after_pkt_grant_id", 32'(grant_id), 32'd2);
    wait_idle();

    // Round robin from a fresh pointer
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    rst       = 1'b0;
    req_data  = {16'h3333, 16'h2222, 16'h1111, 16'hBEEF};
    req_valid = 4'hF;
    push_packet(0, 16'hBEEF);
    push_packet(1, 16'h1111);
    push_packet(2, 16'h2222);
    push_packet(3, 16'h3333);
    push_packet(0, 16'hBEEF);
    base = n_grants;
    wait_grants(base + 5);
    #1 req_valid = 4'h0;
    wait_idle();
    check("rr_grant_id", 32'(grant_id), 32'd0);

    // Backpressure on the HI byte (pointer now 1, requester 2 wins)
    @(posedge clk); #1;
    req_data[47:32] = 16'h1234;
    req_valid       = 4'b0100;
    push_packet(2, 16'h1234);
    base = n_grants;
    wait_grants(base + 1);
    #1 req_valid = 4'h0;
    @(posedge clk);
    @(posedge clk); #1 tx_ready = 1'b0;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      check("stall_data", 32'(tx_data), 32'h12);
      check("stall_valid", 32'(tx_valid), 32'd1);
    end
    @(posedge clk); #1 tx_ready = 1'b1;
    wait_idle();

    // Request inputs change during a packet (pointer now 3)
    @(posedge clk); #1;
    req_data[31:16] = 16'h5678;
    req_data[63:48] = 16'h0F0F;
    req_valid       = 4'b0010;
    push_packet(1, 16'h5678);
    base = n_grants;
    wait_grants(base + 1);
    #1;
    req_data[31:16] = 16'h9ABC;
    req_valid[3]    = 1'b1;
    @(posedge clk); #1 req_valid[3] = 1'b0;
    @(posedge clk); #1 req_valid[3] = 1'b1;
    push_packet(3, 16'h0F0F);
    push_packet(1, 16'h9ABC);
    wait_grants(base + 3);
    #1 req_valid = 4'h0;
    wait_idle();
    check("chg_grant_id", 32'(grant_id), 32'd1);

    // Reset during the LO byte (pointer now 2)
    @(posedge clk); #1;
    req_data[47:32] = 16'h4321;
    req_valid       = 4'b0100;
    push_packet(2, 16'h4321);
    base = n_grants;
    wait_grants(base + 1);
    #1 req_valid = 4'h0;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk); #1;
    tx_ready = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    check("pre_rst_lo_byte", 32'(tx_data), 32'h21);
    check("pre_rst_valid", 32'(tx_valid), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("mid_rst_valid", 32'(tx_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_data", 32'(tx_data), 32'd0);
    check("mid_rst_grant_id", 32'(grant_id), 32'd0);
    exp_bytes.delete();
    @(posedge clk); #1;
    rst             = 1'b0;
    tx_ready        = 1'b1;
    req_data[15:0]  = 16'hCAFE;
    req_data[63:48] = 16'h7777;
    req_valid       = 4'b1001;
    push_packet(0, 16'hCAFE);
    push_packet(3, 16'h7777);
    base = n_grants;
    wait_grants(base + 2);
    #1 req_valid = 4'h0;
    wait_idle();
    check("post_rst_grant_id", 32'(grant_id), 32'd3);
    check("grants_left", 32'(exp_grants.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_report_arbiter.md
# uart_report_arbiter

Round-robin scheduler that shares a single byte-wide UART transmitter between NUM_REQ reporting sources (fault-injection monitors, counters, status words). Each source offers a 16-bit word over a valid/ready handshake. The arbiter frames the winning word into a fixed 5-byte packet: sync, source ID, data high, data low, checksum. It then feeds the bytes one at a time to the downstream byte-level UART TX over a valid/ready handshake. It sits between the monitor logic and the UART serializer.

## Interface
- NUM_REQ, 4: number of requesters; legal range 2..16.
- SYNC_BYTE, 8'hA5: first byte of every packet.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  bit i: requester i offers req_data word i.
- req_data  in  16*NUM_REQ  word i is bits [16*i+15:16*i].
- req_ready  out  NUM_REQ  one-hot or zero; bit i high means requester i's word is accepted this cycle.
- tx_data  out  8  byte to the UART TX.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  UART TX accepts the byte when tx_valid && tx_ready.
- busy  out  1  packet in progress (state != IDLE).
- grant_id  out  4  index of the last granted requester.

## Operation
- States: IDLE, SYNC, ID, HI, LO, CHK.
- **IDLE**
  - tx_valid = 0.
  - If any req_valid is high, the winner is the first set bit searching upward from pointer ptr, wrapping modulo NUM_REQ.
  - req_ready[winner] = 1, combinational, in IDLE only and gated by !rst.
  - On that edge, latch id = winner and word = req_data[winner], set grant_id = winner, and go to SYNC.
- **SYNC, ID, HI, LO, CHK**
  - tx_valid = 1.
  - tx_data is, in order: SYNC_BYTE; {4'h0, id}; word[15:8]; word[7:0]; chk.
  - Advance to the next state only on tx_valid && tx_ready.
- chk = SYNC_BYTE ^ {4'h0,id} ^ word[15:8] ^ word[7:0], computed from the latched values.
- On the CHK transfer: go to IDLE and set ptr = (id + 1) mod NUM_REQ.
- Requester rules:
  - A requester holds req_valid and req_data until it sees req_ready.
  - Deasserting req_valid before a grant is legal; nothing is remembered.
  - Changes on any req input during a packet have no effect.
- Simultaneous requests: exactly one grant per packet. Round-robin guarantees each continuously-valid requester is served within NUM_REQ packets.
- busy = (state != IDLE), registered.

## Timing
- Reset values: state IDLE, ptr 0, grant_id 0, tx_valid 0, tx_data 8'h00, busy 0, req_ready 0.
- Reset mid-packet aborts immediately. After the edge with rst high, all outputs take their reset values; the partial packet is not completed.
- Grant to first byte: req_ready high in cycle N; tx_valid = 1 with SYNC_BYTE in cycle N+1.
- With tx_ready tied high, a packet occupies 5 cycles (N+1..N+5). IDLE is cycle N+6, and the next grant can occur in N+6. Minimum spacing is 6 cycles per packet.
- Stall behaviour: while tx_valid && !tx_ready, tx_data and state are held; tx_valid never drops mid-packet.
- tx_data and tx_valid are registered. When idle, tx_data retains its last value; downstream ignores it while tx_valid = 0.

## Test plan
- **Reset:** hold rst 3 cycles with all req_valid high -> req_ready = 0, tx_valid = 0, busy = 0, grant_id = 0 throughout.
- **Single packet:** req_valid[2] with data 16'h1234, tx_ready = 1 -> req_ready = 4'b0100 for one cycle, then bytes A5, 02, 12, 34, 81 on consecutive cycles, then busy = 0.
- **Round robin:** all four requesters valid continuously; req0 = 16'hBEEF -> grant order 0, 1, 2, 3, 0. Checksum of the req0 packet = F4.
- **Backpressure:** tx_ready low 7 cycles during the HI byte -> tx_data stays 12 with tx_valid = 1, no skipped or duplicated bytes, packet completes correctly.
- **Request change during a packet:** req_data[1] changes and req_valid[3] toggles mid-packet -> the packet in flight is unchanged; the next grant follows ptr.
- **Reset mid-packet:** rst asserted during the LO byte -> next cycle tx_valid = 0 and state IDLE. After release, the next grant starts from ptr = 0 with a full 5-byte packet.
